// File: rtl/regbank_pkg.sv
// Shared definitions for the pipelined register bank: opcode constants,
// the write-qualifying opcode decode and the default write-back entry type.
package regbank_pkg;

  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;
  localparam logic [3:0] OP_NOP = 4'b1100;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_AW     = 4;

  // Write-back entry at the default 16 x 32 geometry; the top level declares
  // its own copy sized from its parameters.
  typedef struct packed {
    logic                  valid;
    logic [DEF_AW-1:0]     dest;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

  // CMP, STR (and its undefined neighbour) and the NOP group leave the
  // destination untouched; every other opcode, LDR included, writes it.
  function automatic logic op_writes_dest(input logic [3:0] opcode);
    logic w_writes;
    casez (opcode)
      4'b1000: w_writes = 1'b0;
      4'b101?: w_writes = 1'b0;
      4'b11??: w_writes = 1'b0;
      default: w_writes = 1'b1;
    endcase
    return w_writes;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Busy scoreboard: one bit per register, set by a reservation at issue and
// cleared by the commit of the write-back stage. A reservation landing on a
// register that is busy and not released in the same cycle raises a sticky
// error flag that only reset clears.
module regbank_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_idx,
  input  logic                rel_valid,
  input  logic [AW-1:0]       rel_idx,
  output logic [NUM_REGS-1:0] busy,
  output logic                rsv_err
);

  localparam logic [NUM_REGS-1:0] ONE_HOT_0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] r_busy;
  logic                r_rsv_err;
  logic [NUM_REGS-1:0] w_rsv_mask;
  logic [NUM_REGS-1:0] w_rel_mask;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_err_set;

  assign w_rsv_mask = rsv_valid ? (ONE_HOT_0 << rsv_idx) : {NUM_REGS{1'b0}};
  assign w_rel_mask = rel_valid ? (ONE_HOT_0 << rel_idx) : {NUM_REGS{1'b0}};
  // Release first, then reserve, so a same-cycle reserve of the committing
  // register keeps it busy.
  assign w_busy_nxt = (r_busy & ~w_rel_mask) | w_rsv_mask;
  assign w_err_set  = rsv_valid & r_busy[rsv_idx] & ~w_rel_mask[rsv_idx];

  // Scoreboard state and sticky reservation error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= {NUM_REGS{1'b0}};
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_rsv_err <= r_rsv_err | w_err_set;
    end
  end

  assign busy    = r_busy;
  assign rsv_err = r_rsv_err;

endmodule

// File: rtl/regbank_pipelined.sv
// NUM_REGS x DATA_W register bank with NUM_RD combinational read ports,
// opcode-gated writes through a one-entry write-back stage (forwarded to the
// read ports), and a per-register busy scoreboard for issue logic.
// Optional build macro REGBANK_ZERO_REG_EN: R0 reads as zero, writes and
// reservations aimed at R0 are dropped.
module regbank_pipelined
  import regbank_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_req,
  input  logic [3:0]                   wr_opcode,
  input  logic [AW-1:0]                wr_dest,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         regbank_enable,
  input  logic [NUM_RD*AW-1:0]         rd_sel,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  input  logic                         rsv_req,
  input  logic [AW-1:0]                rsv_dest,
  output logic [NUM_REGS-1:0]          busy,
  output logic                         rsv_err,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

  typedef struct packed {
    logic              valid;
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] data;
  } wb_stage_t;

  wb_stage_t         r_wb;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_dest_ok;
  logic              w_rsv_ok;
  logic              w_wr_go;

`ifdef REGBANK_ZERO_REG_EN
  assign w_dest_ok = (wr_dest != {AW{1'b0}});
  assign w_rsv_ok  = (rsv_dest != {AW{1'b0}});
`else
  assign w_dest_ok = 1'b1;
  assign w_rsv_ok  = 1'b1;
`endif

  assign w_wr_go = wr_req & regbank_enable & op_writes_dest(wr_opcode) & w_dest_ok;

  // Write-back stage: holds the newest accepted write for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb <= {(1 + AW + DATA_W){1'b0}};
    end else begin
      r_wb.valid <= w_wr_go;
      r_wb.dest  <= wr_dest;
      r_wb.data  <= wr_data;
    end
  end

  // Architectural array: commits the write-back entry one edge after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (r_wb.valid) begin
      r_regs[r_wb.dest] <= r_wb.data;
    end else begin
      r_regs <= r_regs;
    end
  end

  // Flattened view of the committed array, no forwarding.
  always_comb begin
    regs_flat = {(NUM_REGS*DATA_W){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_W +: DATA_W] = r_regs[i];
    end
`ifdef REGBANK_ZERO_REG_EN
    regs_flat[DATA_W-1:0] = {DATA_W{1'b0}};
`endif
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     w_sel;
    logic [DATA_W-1:0] w_val;

    assign w_sel = rd_sel[k*AW +: AW];

    // Read mux: the pending write-back value overrides the array entry.
    always_comb begin
      w_val = {DATA_W{1'b0}};
      if (r_wb.valid && (r_wb.dest == w_sel)) begin
        w_val = r_wb.data;
      end else begin
        w_val = r_regs[w_sel];
      end
`ifdef REGBANK_ZERO_REG_EN
      if (w_sel == {AW{1'b0}}) begin
        w_val = {DATA_W{1'b0}};
      end else begin
        w_val = w_val;
      end
`endif
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_val;
  end

  regbank_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rsv_valid (rsv_req & w_rsv_ok),
    .rsv_idx   (rsv_dest),
    .rel_valid (r_wb.valid),
    .rel_idx   (r_wb.dest),
    .busy      (busy),
    .rsv_err   (rsv_err)
  );

endmodule

// File: tb/tb_regbank_pipelined.sv
// Directed bench for regbank_pipelined at the default 16 x 32, two read ports.
module tb_regbank_pipelined;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [3:0]    wr_opcode;
  logic [3:0]    wr_dest;
  logic [31:0]   wr_data;
  logic          regbank_enable;
  logic [7:0]    rd_sel;
  logic [63:0]   rd_data;
  logic          rsv_req;
  logic [3:0]    rsv_dest;
  logic [15:0]   busy;
  logic          rsv_err;
  logic [511:0]  regs_flat;

  int checks   = 0;
  int failures = 0;

  regbank_pipelined dut (
    .clk            (clk),
    .rst            (rst),
    .wr_req         (wr_req),
    .wr_opcode      (wr_opcode),
    .wr_dest        (wr_dest),
    .wr_data        (wr_data),
    .regbank_enable (regbank_enable),
    .rd_sel         (rd_sel),
    .rd_data        (rd_data),
    .rsv_req        (rsv_req),
    .rsv_dest       (rsv_dest),
    .busy           (busy),
    .rsv_err        (rsv_err),
    .regs_flat      (regs_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_req;
    logic [3:0]  op;
    logic [3:0]  dest;
    logic [31:0] data;
    logic        en;
    logic [3:0]  sel0;
    logic [3:0]  sel1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [3:0]  fidx;
    logic [31:0] expf;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flat(input int idx);
    return regs_flat[idx*32 +: 32];
  endfunction

  task automatic idle();
    wr_req  = 1'b0;
    rsv_req = 1'b0;
  endtask

  initial begin
    logic [31:0] zr_exp;
`ifdef REGBANK_ZERO_REG_EN
    zr_exp = 32'h0000_0000;
`else
    zr_exp = 32'h0000_0055;
`endif

    //          req  op       dest   data           en    s0     s1     exp0           exp1           fidx   expf
    vecs[0]  = '{1'b1, 4'b0000, 4'd5, 32'hDEADBEEF, 1'b1, 4'd5, 4'd3, 32'hDEADBEEF, 32'h00000000, 4'd5, 32'h00000000};
    vecs[1]  = '{1'b1, 4'b1000, 4'd3, 32'h11111111, 1'b1, 4'd3, 4'd5, 32'h00000000, 32'hDEADBEEF, 4'd5, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 4'b1010, 4'd3, 32'h22222222, 1'b1, 4'd3, 4'd5, 32'h00000000, 32'hDEADBEEF, 4'd3, 32'h00000000};
    vecs[3]  = '{1'b1, 4'b1011, 4'd3, 32'h33333333, 1'b1, 4'd3, 4'd5, 32'h00000000, 32'hDEADBEEF, 4'd3, 32'h00000000};
    vecs[4]  = '{1'b1, 4'b1100, 4'd3, 32'h44444444, 1'b1, 4'd3, 4'd5, 32'h00000000, 32'hDEADBEEF, 4'd3, 32'h00000000};
    vecs[5]  = '{1'b1, 4'b1111, 4'd3, 32'h55555555, 1'b1, 4'd3, 4'd5, 32'h00000000, 32'hDEADBEEF, 4'd3, 32'h00000000};
    vecs[6]  = '{1'b1, 4'b0000, 4'd3, 32'h66666666, 1'b0, 4'd3, 4'd5, 32'h00000000, 32'hDEADBEEF, 4'd3, 32'h00000000};
    vecs[7]  = '{1'b0, 4'b0000, 4'd3, 32'h77777777, 1'b1, 4'd3, 4'd5, 32'h00000000, 32'hDEADBEEF, 4'd3, 32'h00000000};
    vecs[8]  = '{1'b1, 4'b1001, 4'd3, 32'h12345678, 1'b1, 4'd3, 4'd5, 32'h12345678, 32'hDEADBEEF, 4'd3, 32'h00000000};
    vecs[9]  = '{1'b1, 4'b0001, 4'd7, 32'h00000001, 1'b1, 4'd7, 4'd3, 32'h00000001, 32'h12345678, 4'd3, 32'h12345678};
    vecs[10] = '{1'b1, 4'b0010, 4'd7, 32'h00000002, 1'b1, 4'd7, 4'd3, 32'h00000002, 32'h12345678, 4'd7, 32'h00000001};
    vecs[11] = '{1'b1, 4'b0111, 4'd7, 32'h00000003, 1'b1, 4'd7, 4'd3, 32'h00000003, 32'h12345678, 4'd7, 32'h00000002};
    vecs[12] = '{1'b0, 4'b0000, 4'd0, 32'h00000000, 1'b1, 4'd7, 4'd5, 32'h00000003, 32'hDEADBEEF, 4'd7, 32'h00000003};

    rst = 1'b1; wr_req = 1'b0; wr_opcode = 4'b0000; wr_dest = 4'd0; wr_data = 32'h0;
    regbank_enable = 1'b1; rd_sel = 8'h00; rsv_req = 1'b0; rsv_dest = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state on every read port and output.
    for (int s = 0; s < 16; s += 2) begin
      rd_sel = {s[3:0] + 4'd1, s[3:0]};
      #1;
      chk("reset_rd", {32'h0, rd_data[31:0] | rd_data[63:32]}, 64'h0);
    end
    chk("reset_flat", {63'h0, regs_flat == 512'h0}, 64'h1);
    chk("reset_busy", {48'h0, busy}, 64'h0);
    chk("reset_err", {63'h0, rsv_err}, 64'h0);

    // Table: writes, gating, forwarding and commit latency.
    for (int i = 0; i < 13; i++) begin
      wr_req = vecs[i].wr_req; wr_opcode = vecs[i].op; wr_dest = vecs[i].dest;
      wr_data = vecs[i].data; regbank_enable = vecs[i].en;
      rd_sel = {vecs[i].sel1, vecs[i].sel0};
      tick();
      chk($sformatf("vec%0d_rd0", i), {32'h0, rd_data[31:0]}, {32'h0, vecs[i].exp0});
      chk($sformatf("vec%0d_rd1", i), {32'h0, rd_data[63:32]}, {32'h0, vecs[i].exp1});
      chk($sformatf("vec%0d_flat", i), {32'h0, flat(int'(vecs[i].fidx))}, {32'h0, vecs[i].expf});
      chk($sformatf("vec%0d_busy", i), {48'h0, busy}, 64'h0);
    end
    regbank_enable = 1'b1;

    // R0 write: ordinary register by default, hardwired zero with the macro.
    wr_req = 1'b1; wr_opcode = 4'b0000; wr_dest = 4'd0; wr_data = 32'h55; rd_sel = 8'h00;
    tick();
    chk("r0_fwd", {32'h0, rd_data[31:0]}, {32'h0, zr_exp});
    idle();
    tick();
    chk("r0_flat", {32'h0, flat(0)}, {32'h0, zr_exp});
    chk("r0_busy", {63'h0, busy[0]}, 64'h0);

    // Reserve and commit R9 on the same edge: reserve wins, no error.
    rsv_req = 1'b1; rsv_dest = 4'd9;
    tick();
    chk("r9_rsv", {48'h0, busy}, 64'h0200);
    rsv_req = 1'b0; wr_req = 1'b1; wr_dest = 4'd9; wr_data = 32'h9;
    tick();
    chk("r9_pending", {48'h0, busy}, 64'h0200);
    wr_req = 1'b0; rsv_req = 1'b1; rsv_dest = 4'd9;
    tick();
    chk("r9_same_cycle_busy", {48'h0, busy}, 64'h0200);
    chk("r9_same_cycle_err", {63'h0, rsv_err}, 64'h0);
    rsv_req = 1'b0; wr_req = 1'b1; wr_dest = 4'd9;
    tick();
    idle();
    tick();
    chk("r9_clear", {48'h0, busy}, 64'h0);

    // Reserve R4, write it, then double reservation sets sticky error.
    rsv_req = 1'b1; rsv_dest = 4'd4;
    tick();
    chk("r4_rise", {48'h0, busy}, 64'h0010);
    rsv_req = 1'b0; wr_req = 1'b1; wr_dest = 4'd4; wr_data = 32'hAA;
    tick();
    chk("r4_edgeN", {48'h0, busy}, 64'h0010);
    idle();
    tick();
    chk("r4_fall", {48'h0, busy}, 64'h0);
    rsv_req = 1'b1; rsv_dest = 4'd4;
    tick();
    chk("r4_rsv2_err", {63'h0, rsv_err}, 64'h0);
    tick();
    chk("r4_double_err", {63'h0, rsv_err}, 64'h1);
    chk("r4_double_busy", {48'h0, busy}, 64'h0010);
    idle();
    tick(); tick(); tick();
    chk("r4_err_sticky", {63'h0, rsv_err}, 64'h1);

    // Reset while a write-back entry is in flight discards it.
    wr_req = 1'b1; wr_opcode = 4'b0000; wr_dest = 4'd10; wr_data = 32'hCAFE; rd_sel = 8'h0A;
    tick();
    chk("rst_pre_fwd", {32'h0, rd_data[31:0]}, 64'hCAFE);
    wr_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rd", {32'h0, rd_data[31:0]}, 64'h0);
    chk("rst_flat", {63'h0, regs_flat == 512'h0}, 64'h1);
    chk("rst_busy", {48'h0, busy}, 64'h0);
    chk("rst_err", {63'h0, rsv_err}, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_post_rd", {32'h0, rd_data[31:0]}, 64'h0);
    chk("rst_post_flat", {32'h0, flat(10)}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
